// File: rtl/writeback_arbiter.sv
// writeback_arbiter: sole driver of the register-file write port.
// Pipeline writeback passes through with zero latency; long-latency results
// (MUL/DIV, late loads) are queued in a small FIFO and drained into idle
// write-port cycles. A pending-destination scoreboard is kept for the hazard unit.
// Ports:
//   clk, rst                     clock, synchronous active-low reset
//   RegWriteW, RDW, ResultW      W-stage writeback request
//   issue_valid, issue_rd        multi-cycle op issued by decode
//   lr_valid/lr_ready, lr_rd, lr_data   long-result enqueue handshake
//   WE3, A3, WD3                 register-file write port (combinational)
//   busy_mask                    outstanding long-result destinations
//   stall_req                    ask for a bubble so the FIFO can drain
//   sb_err                       sticky: issue to an already-busy register
package writeback_arbiter_pkg;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } lr_entry_t;
endpackage

module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteW,
  input  logic [REG_W-1:0]  RDW,
  input  logic [DATA_W-1:0] ResultW,
  input  logic              issue_valid,
  input  logic [REG_W-1:0]  issue_rd,
  input  logic              lr_valid,
  output logic              lr_ready,
  input  logic [REG_W-1:0]  lr_rd,
  input  logic [DATA_W-1:0] lr_data,
  output logic              WE3,
  output logic [REG_W-1:0]  A3,
  output logic [DATA_W-1:0] WD3,
  output logic [31:0]       busy_mask,
  output logic              stall_req,
  output logic              sb_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  lr_entry_t         mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [STV_W-1:0]  starve_cnt;
  logic [31:0]       busy_q;
  logic [31:0]       busy_nxt;
  logic              sb_err_q;

  lr_entry_t         head;
  logic              pwb;
  logic              nonempty;
  logic              push;
  logic              pop;
  logic              blocked;

  assign head     = mem[rd_ptr];
  assign pwb      = RegWriteW && (RDW != '0);
  assign nonempty = (count != '0);
  // lr_ready is forced low during reset so nothing is accepted then.
  assign lr_ready = rst && (count < CNT_W'(DEPTH));
  assign push     = lr_valid && lr_ready;
  assign pop      = !pwb && nonempty;
  assign blocked  = pwb && nonempty;

  assign busy_mask = busy_q;
  assign sb_err    = sb_err_q;
  assign stall_req = rst && (starve_cnt == STV_W'(STARVE_LIMIT));

  // Write-port mux: pipeline first, then FIFO head; rd=0 entries drain silently.
  always_comb begin
    WE3 = 1'b0;
    A3  = '0;
    WD3 = '0;
    if (rst) begin
      if (pwb) begin
        WE3 = 1'b1;
        A3  = RDW;
        WD3 = ResultW;
      end else if (nonempty) begin
        WE3 = (head.rd != '0);
        A3  = head.rd;
        WD3 = head.data;
      end
    end
  end

  // Scoreboard next value: clear on pop, then set on issue so set wins.
  always_comb begin
    busy_nxt = busy_q;
    if (pop && (head.rd != '0)) busy_nxt[head.rd] = 1'b0;
    if (issue_valid && (issue_rd != '0)) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{rd: lr_rd, data: lr_data};
  end

  // Pointers, occupancy, scoreboard, starvation counter and error flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      busy_q     <= '0;
      starve_cnt <= '0;
      sb_err_q   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count  <= count + CNT_W'(push) - CNT_W'(pop);
      busy_q <= busy_nxt;
      if (issue_valid && (issue_rd != '0) && busy_q[issue_rd]) sb_err_q <= 1'b1;
      if (!blocked) begin
        starve_cnt <= '0;
      end else if (starve_cnt != STV_W'(STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + STV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Testbench for writeback_arbiter: directed scenarios followed by randomized
// traffic, checked per cycle against a queue-based reference model.
module tb_writeback_arbiter;

  localparam int unsigned DEPTH        = 4;
  localparam int unsigned STARVE_LIMIT = 8;

  logic        clk;
  logic        rst;
  logic        RegWriteW;
  logic [4:0]  RDW;
  logic [31:0] ResultW;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        lr_valid;
  logic        lr_ready;
  logic [4:0]  lr_rd;
  logic [31:0] lr_data;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic [31:0] busy_mask;
  logic        stall_req;
  logic        sb_err;

  writeback_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .lr_valid(lr_valid), .lr_ready(lr_ready), .lr_rd(lr_rd), .lr_data(lr_data),
    .WE3(WE3), .A3(A3), .WD3(WD3),
    .busy_mask(busy_mask), .stall_req(stall_req), .sb_err(sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic        ready;
    logic        stall;
    logic [31:0] busy;
    logic        sberr;
  } exp_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  exp_t        exp_q[$];
  ent_t        mq[$];
  logic [31:0] m_busy;
  bit          m_sberr;
  int          m_blocked;
  int          checks;
  int          failures;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: applies one cycle of inputs, records what the DUT must
  // show during that cycle, then advances the model across the clock edge.
  task automatic drive(input bit r, input bit rw, input logic [4:0] rdw, input logic [31:0] res,
                       input bit iv, input logic [4:0] ird,
                       input bit lv, input logic [4:0] lrd, input logic [31:0] ld);
    exp_t        e;
    ent_t        h;
    ent_t        n;
    bit          pwb;
    bit          acc;
    bit          pop;
    logic [31:0] busy_pre;
    rst = r; RegWriteW = rw; RDW = rdw; ResultW = res;
    issue_valid = iv; issue_rd = ird;
    lr_valid = lv; lr_rd = lrd; lr_data = ld;
    pwb     = rw && (rdw != 0);
    e.we    = 1'b0;
    e.a3    = '0;
    e.wd3   = '0;
    e.ready = r && (mq.size() < DEPTH);
    e.stall = r && (m_blocked >= STARVE_LIMIT);
    e.busy  = m_busy;
    e.sberr = m_sberr;
    if (r) begin
      if (pwb) begin
        e.we = 1'b1; e.a3 = rdw; e.wd3 = res;
      end else if (mq.size() > 0) begin
        h = mq[0];
        e.we = (h.rd != 0); e.a3 = h.rd; e.wd3 = h.data;
      end
    end
    exp_q.push_back(e);
    if (!r) begin
      mq.delete();
      m_busy    = '0;
      m_blocked = 0;
      m_sberr   = 1'b0;
    end else begin
      acc = lv && (mq.size() < DEPTH);
      pop = !pwb && (mq.size() > 0);
      if (pwb && (mq.size() > 0)) begin
        if (m_blocked < STARVE_LIMIT) m_blocked++;
      end else begin
        m_blocked = 0;
      end
      busy_pre = m_busy;
      if (pop) begin
        h = mq.pop_front();
        if (h.rd != 0) m_busy[h.rd] = 1'b0;
      end
      if (acc) begin
        n.rd = lrd; n.data = ld;
        mq.push_back(n);
      end
      if (iv && (ird != 0)) begin
        if (busy_pre[ird]) m_sberr = 1'b1;
        m_busy[ird] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: pops one expected record per cycle, samples away from the edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("WE3",       32'(WE3),       32'(e.we));
        chk("A3",        32'(A3),        32'(e.a3));
        chk("WD3",       WD3,            e.wd3);
        chk("lr_ready",  32'(lr_ready),  32'(e.ready));
        chk("stall_req", 32'(stall_req), 32'(e.stall));
        chk("busy_mask", busy_mask,      e.busy);
        chk("sb_err",    32'(sb_err),    32'(e.sberr));
      end
    end
  end

  initial begin : stimulus
    int pct;
    checks = 0; failures = 0;
    m_busy = '0; m_sberr = 1'b0; m_blocked = 0;
    rst = 1'b0; RegWriteW = 1'b0; RDW = '0; ResultW = '0;
    issue_valid = 1'b0; issue_rd = '0; lr_valid = 1'b0; lr_rd = '0; lr_data = '0;
    @(posedge clk);
    #1;

    // Reset held with active requests
    drive(0, 1, 5, 32'h1111_1111, 0, 0, 1, 6, 32'h2222_2222);
    drive(0, 1, 5, 32'h1111_1111, 0, 0, 1, 6, 32'h2222_2222);
    idle(1);

    // Passthrough, including rd=0
    drive(1, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
    drive(1, 1, 0, 32'hCAFE_F00D, 0, 0, 0, 0, 0);

    // Scoreboard set, then drain clears it
    drive(1, 0, 0, 0, 1, 7, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 1, 7, 32'h0000_1234);
    idle(3);

    // Fill under pipeline pressure, fifth push held off, then drain in order
    for (int i = 0; i < 5; i++) drive(1, 1, 3, 32'h3000_0000 + i, 0, 0, 1, 5'(10 + i), 32'hA000_0000 + i);
    idle(5);

    // Starvation: one queued entry blocked by continuous pipeline writes
    drive(1, 1, 3, 32'h0000_0033, 1, 4, 1, 4, 32'h0000_0044);
    for (int i = 0; i < 9; i++) drive(1, 1, 3, 32'h0000_0100 + i, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 2, 32'h0000_0200, 0, 0, 0, 0, 0);
    idle(2);

    // Issue x9 while its pop clears it; issuing a busy reg is flagged
    drive(1, 1, 1, 32'h1, 1, 9, 1, 9, 32'h0000_0999);
    drive(1, 0, 0, 0, 1, 9, 0, 0, 0);
    idle(3);

    // rd=0 long result drains with write disabled
    drive(1, 1, 2, 32'h5, 0, 0, 1, 0, 32'h0BAD_0BAD);
    idle(2);

    // Reset in the middle of a full FIFO drops everything
    for (int i = 0; i < 4; i++) drive(1, 1, 8, 32'h8, 1, 5'(20 + i), 1, 5'(20 + i), 32'hB000_0000 + i);
    drive(0, 1, 8, 32'h8, 0, 0, 1, 1, 32'h1);
    idle(3);

    // Randomized traffic with varying pipeline pressure and rare resets
    pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if ((c % 64) == 0) pct = (($urandom_range(0, 2) == 0) ? 15 : (($urandom_range(0, 1) == 0) ? 60 : 97));
      drive(($urandom_range(0, 299) != 0),
            ($urandom_range(0, 99) < pct), 5'($urandom_range(0, 31)), $urandom,
            ($urandom_range(0, 4) == 0), 5'($urandom_range(0, 31)),
            ($urandom_range(0, 1) == 0), 5'($urandom_range(0, 31)), $urandom);
    end
    idle(8);

    // Let the monitor consume the last records within a bounded wait
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d required=0 records left", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
